// File: rtl/imm_encoder.sv
// imm_encoder
// Splits a 32-bit constant into the shortest sequence of (imm16, extop)
// beats that the immediate extender expands back to the same value.
// Words that fit one extension mode give one beat. Other words give two
// beats: a lui beat with the high half, then a zero-extended beat with
// the low half. The consumer ORs the two beats together.
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous, active-high reset
//   in_valid    in_imm32 is valid
//   in_ready    encoder accepts in_imm32 this cycle
//   in_imm32    constant to encode
//   out_valid   out_imm16 / out_extop / out_last are valid
//   out_ready   consumer takes the current beat
//   out_imm16   immediate field
//   out_extop   3'b000 ZeroExt, 3'b001 SignExt, 3'b010 LuiExt
//   out_last    final beat of the current constant
//   pair_count  saturating count of constants that needed two beats
//
// state  | meaning
// IDLE   | no beat pending
// SINGLE | one-beat result held
// HI     | lui beat of a pair held, low half waiting in lo_q
// LO     | zero-extended low-half beat of a pair held

module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_imm32,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_imm16,
  output logic [2:0]       out_extop,
  output logic             out_last,
  output logic [CNT_W-1:0] pair_count
);

  localparam logic [2:0] EXT_ZERO = 3'b000;
  localparam logic [2:0] EXT_SIGN = 3'b001;
  localparam logic [2:0] EXT_LUI  = 3'b010;

  typedef enum logic [1:0] {IDLE, SINGLE, HI, LO} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] data_q;
  logic [15:0] lo_q;
  logic [2:0]  ext_q;

  logic [15:0] w_hi;
  logic [15:0] w_lo;
  logic        enc_pair;
  logic [15:0] enc_imm;
  logic [2:0]  enc_ext;
  logic        accept;
  logic        out_hs;

  assign w_hi = in_imm32[31:16];
  assign w_lo = in_imm32[15:0];

  // Encoding rules in priority order. The result is only ever captured
  // into registers, so in_imm32 never reaches the outputs combinationally.
  always_comb begin
    enc_pair = 1'b0;
    enc_imm  = w_lo;
    enc_ext  = EXT_SIGN;
    if (in_imm32 == {{16{w_lo[15]}}, w_lo}) begin
      enc_imm = w_lo;
      enc_ext = EXT_SIGN;
    end else if (w_hi == 16'h0000) begin
      enc_imm = w_lo;
      enc_ext = EXT_ZERO;
    end else if (w_lo == 16'h0000) begin
      enc_imm = w_hi;
      enc_ext = EXT_LUI;
    end else begin
      enc_pair = 1'b1;
      enc_imm  = w_hi;
      enc_ext  = EXT_LUI;
    end
  end

  assign out_hs   = out_valid && out_ready;
  // Accepting on the last-beat handshake keeps single-beat words at one per cycle.
  assign in_ready = (state == IDLE) || (out_hs && out_last);
  assign accept   = in_valid && in_ready;

  // State register and datapath capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      data_q     <= '0;
      lo_q       <= '0;
      ext_q      <= EXT_ZERO;
      pair_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        data_q <= enc_imm;
        ext_q  <= enc_ext;
        lo_q   <= w_lo;
        if (enc_pair && !(&pair_count))
          pair_count <= pair_count + 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept)
          state_nxt = enc_pair ? HI : SINGLE;
      end
      SINGLE, LO: begin
        if (out_hs) begin
          if (accept)
            state_nxt = enc_pair ? HI : SINGLE;
          else
            state_nxt = IDLE;
        end
      end
      HI: begin
        if (out_hs)
          state_nxt = LO;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_imm16 = 16'h0000;
    out_extop = EXT_ZERO;
    case (state)
      SINGLE: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_imm16 = data_q;
        out_extop = ext_q;
      end
      HI: begin
        out_valid = 1'b1;
        out_last  = 1'b0;
        out_imm16 = data_q;
        out_extop = EXT_LUI;
      end
      LO: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_imm16 = lo_q;
        out_extop = EXT_ZERO;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Immediate encoder for the constant-loading path. Accepts 32-bit constants over a valid/ready handshake and emits the shortest sequence of (Imm16, ExtOp) fields that the datapath's immediate extender expands back to the same value. Emits one beat for constants that fit a single extension mode, and two beats (lui then ori) otherwise. It is the encoder counterpart of the immediate extender and sits in front of the instruction/constant generator feeding the datapath.

## Interface
Parameters:
- CNT_W, 16, width of the saturating two-beat counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_imm32 is valid.
- in_ready  output  1  encoder accepts in_imm32 this cycle.
- in_imm32  input  32  constant to encode.
- out_valid  output  1  out_imm16, out_extop and out_last are valid.
- out_ready  input  1  consumer takes the current beat.
- out_imm16  output  16  immediate field.
- out_extop  output  3  extension mode: 3'b000 ZeroExt, 3'b001 SignExt, 3'b010 LuiExt. No other code is ever driven.
- out_last  output  1  final beat of the current constant.
- pair_count  output  CNT_W  number of constants that needed two beats. Saturates at all-ones.

## Operation
- Transfers occur when valid && ready are both high at a rising edge.
- Encoding priority, evaluated on the accepted word W (H = W[31:16], L = W[15:0]):
  1. W == {{16{L[15]}},L}: one beat, SignExt, imm16 = L. This includes W = 0.
  2. Else H == 0: one beat, ZeroExt, imm16 = L.
  3. Else L == 0: one beat, LuiExt, imm16 = H.
  4. Else two beats: beat 1 is LuiExt with imm16 = H and last = 0. Beat 2 is ZeroExt with imm16 = L and last = 1. The consumer ORs the two beats.
- FSM states:
  - IDLE: no beat pending; out_valid = 0.
  - SINGLE: one-beat result held.
  - HI: beat 1 of a pair held; the low half is stored in an internal register.
  - LO: beat 2 held.
- Transitions:
  - IDLE + accept → SINGLE or HI.
  - SINGLE + out handshake → IDLE, or directly to SINGLE/HI if a new word is accepted in the same cycle.
  - HI + out handshake → LO.
  - LO + out handshake → IDLE, or SINGLE/HI if a new word is accepted in the same cycle.
  - In any state other than IDLE, the state holds without an out handshake.
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last). It is combinational from out_ready and is 0 in HI.
- Output stability: while out_valid && !out_ready, out_imm16, out_extop and out_last hold constant.
- pair_count increments by 1 on each accept that takes rule 4, and stops at 2^CNT_W-1.
- in_imm32 is ignored when in_valid = 0 or in_ready = 0.

## Timing
- Reset (synchronous, the cycle after reset is sampled high):
  - state = IDLE
  - out_valid = 0, out_imm16 = 0, out_extop = 3'b000, out_last = 0
  - pair_count = 0
  - internal low-half register = 0
  - in_ready = 1 in the first cycle after reset.
- Reset mid-operation (including in HI with beat 2 pending) discards the pending beat. No partial pair is ever emitted afterwards.
- Latency: a word accepted at edge N has its first beat valid after edge N. There is no combinational path from in_imm32 to the outputs.
- Throughput:
  - One-beat words: one word per cycle with out_ready held high.
  - Two-beat words: one word per 2 cycles.
- A simultaneous last-beat output handshake and input accept loads the new beat in the same edge, with no bubble.
- A single accept updates pair_count exactly once, regardless of output stalls.

## Test plan
- Reset then idle: assert reset 2 cycles → out_valid = 0, out_extop = 000, pair_count = 0, in_ready = 1.
- Single-beat modes, out_ready = 1, back-to-back inputs:
  - 0x00000000 → SignExt/0x0000/last = 1
  - 0xFFFF8000 → SignExt/0x8000
  - 0x00008000 → ZeroExt/0x8000
  - 0x12340000 → LuiExt/0x1234
  - These four beats arrive on four consecutive cycles.
- Pair: 0x12345678 → beat LuiExt/0x1234/last = 0, then ZeroExt/0x5678/last = 1. in_ready = 0 during beat 1. pair_count = 1.
- Backpressure: hold out_ready = 0 for 5 cycles on beat 1 of 0xDEADBEEF → outputs stable at LuiExt/0xDEAD, in_ready = 0. After release: ZeroExt/0xBEEF, then accept the next word on the same edge as the last beat.
- Reset in HI: send 0xCAFEF00D, assert reset while beat 1 is stalled → the next cycle has out_valid = 0 and pair_count = 0. No 0xF00D beat ever appears.
- Saturation (CNT_W = 2): send 5 pair words → pair_count stops at 3.
